// File: rtl/hero_write_rx.sv
// Receive end of the hero write bus. Frames qualified beats into transactions
// (VALID* DONE), buffers them in a FIFO and presents them as a ready/valid stream.
// Each pop returns one credit to the sender.

package hero_write_pkg;
    localparam int HERO_W        = 36;
    localparam int ANOTHER_PARAM = 2;

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_VALID = 2'd1,
        CYC_DONE  = 2'd2
    } cycle_type_t;

    typedef struct packed {
        logic [ANOTHER_PARAM-1:0] f3;
        logic [ANOTHER_PARAM-1:0] f2;
        logic [ANOTHER_PARAM-1:0] f1;
        logic [ANOTHER_PARAM-1:0] f0;
    } sub_struct_t;

    typedef struct packed {
        cycle_type_t        cycle_type;
        logic [HERO_W-1:0]  wdat;
        sub_struct_t        another_type_reference;
        logic               clk_en;
    } hero_write_t;
endpackage

module hero_write_rx
    import hero_write_pkg::*;
#(
    parameter int HERO_WIDTH = HERO_W,
    parameter int SIDE_WIDTH = $bits(sub_struct_t),
    parameter int DEPTH      = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  hero_write_t                    in_hero,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [HERO_WIDTH-1:0]          out_wdat,
    output logic [SIDE_WIDTH-1:0]          out_side,
    output logic                           out_last,
    output logic                           out_err,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
    output logic                           credit_return,
    output logic                           err_overflow,
    output logic                           err_too_long
);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [HERO_WIDTH-1:0] wdat;
        logic [SIDE_WIDTH-1:0] side;
        logic                  last;
        logic                  err;
        logic [BW-1:0]         beats;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_SKIP,
        S_DROP,
        S_TERM
    } state_t;

    state_t        state, nstate;
    logic [BW-1:0] cnt, ncnt, cnt_inc;
    entry_t        mem [DEPTH];
    entry_t        head, push_e, term_e;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          qual, is_done, pop, push, space;
    logic          ovf, too_long;

    assign qual    = in_hero.clk_en && (in_hero.cycle_type != CYC_IDLE);
    assign is_done = in_hero.cycle_type == CYC_DONE;
    assign pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign space   = (count != CW'(DEPTH)) || pop;
    assign cnt_inc = cnt + 1'b1;

    // Terminator closes a transaction whose tail was lost; carries accepted beats only.
    assign term_e  = '{wdat: '0, side: '0, last: 1'b1, err: 1'b1, beats: cnt};

    // Framing FSM: decides whether this cycle pushes, what it pushes, and error pulses.
    always_comb begin
        push          = 1'b0;
        push_e.wdat   = HERO_WIDTH'(in_hero.wdat);
        push_e.side   = SIDE_WIDTH'(in_hero.another_type_reference);
        push_e.last   = 1'b0;
        push_e.err    = 1'b0;
        push_e.beats  = cnt_inc;
        nstate        = state;
        ncnt          = cnt;
        ovf           = 1'b0;
        too_long      = 1'b0;
        case (state)
            S_IDLE, S_ACTIVE: begin
                if (qual) begin
                    if (!space) begin
                        ovf    = 1'b1;
                        nstate = is_done ? S_TERM : S_DROP;
                    end else begin
                        push = 1'b1;
                        if (is_done) begin
                            push_e.last = 1'b1;
                            ncnt        = '0;
                            nstate      = S_IDLE;
                        end else if (cnt_inc == BW'(MAX_BEATS)) begin
                            push_e.last = 1'b1;
                            push_e.err  = 1'b1;
                            too_long    = 1'b1;
                            ncnt        = '0;
                            nstate      = S_SKIP;
                        end else begin
                            ncnt   = cnt_inc;
                            nstate = S_ACTIVE;
                        end
                    end
                end
            end
            S_SKIP: begin
                if (qual && is_done) begin
                    nstate = S_IDLE;
                end
            end
            S_DROP: begin
                // Already reported; swallow VALIDs quietly until DONE.
                if (qual && is_done) begin
                    if (space) begin
                        push   = 1'b1;
                        push_e = term_e;
                        ncnt   = '0;
                        nstate = S_IDLE;
                    end else begin
                        nstate = S_TERM;
                    end
                end
            end
            S_TERM: begin
                // Any beat here is a sender credit violation.
                if (qual) begin
                    ovf = 1'b1;
                end
                if (space) begin
                    push   = 1'b1;
                    push_e = term_e;
                    ncnt   = '0;
                    nstate = S_IDLE;
                end
            end
            default: begin
                nstate = S_IDLE;
                ncnt   = '0;
            end
        endcase
    end

    // FSM state and running beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_e;
    end

    assign head          = mem[rptr];
    assign out_valid     = count != '0;
    assign out_wdat      = out_valid ? head.wdat  : '0;
    assign out_side      = out_valid ? head.side  : '0;
    assign out_last      = out_valid && head.last;
    assign out_err       = out_valid && head.err;
    assign out_beats     = out_valid ? head.beats : '0;
    assign credit_return = pop;
    assign err_overflow  = ovf;
    assign err_too_long  = too_long;
endmodule
